// File: rtl/onchip_mem_tester.sv
// onchip_mem_tester
//
// Avalon-MM master that self-tests a single-port on-chip RAM through its s1
// port. On an accepted start it writes pattern(i) = seed + i to the words
// base_addr + i (wrapping at the top of memory), reads the same region back,
// compares every returned word with the pattern and reports the outcome.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle run request, honoured only while idle
//   base_addr         first word address of the region under test
//   length            word count, clamped to 2^ADDR_W
//   seed              pattern seed
//   hold              stall request; freezes this master and the slave
//   busy, done, pass  run status; done is a one-cycle pulse
//   error_count       number of mismatching words in the last run
//   first_err_addr    address of the first mismatch, 0 if none
//   address, byteenable, chipselect, write, writedata, clken, readdata
//                     Avalon-MM master side of the RAM slave port
module onchip_mem_tester #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     seed,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       error_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata
);

    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        idx_q, idx_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [DATA_W-1:0]      seed_q, seed_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic [DATA_W-1:0]      writedata_q, writedata_d;
    logic                   cs_q, cs_d;
    logic                   write_q, write_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [ADDR_W:0]        err_q, err_d;
    logic [ADDR_W-1:0]      first_q, first_d;

    // Expected-value pipeline: stage 0 receives the read issued this cycle,
    // stage READ_LAT-1 lines up with the slave's readdata.
    logic [READ_LAT-1:0]                pipe_vld_q, pipe_vld_d;
    logic [READ_LAT-1:0][DATA_W-1:0]    pipe_exp_q, pipe_exp_d;
    logic [READ_LAT-1:0][ADDR_W-1:0]    pipe_adr_q, pipe_adr_d;

    logic [ADDR_W:0]        len_clamped;
    logic                   last_word;
    logic                   push;
    logic [READ_LAT-1:0]    older_vld;
    logic [DATA_W-1:0]      exp_word;

    // Next-state computation. Every register holds its value while hold is
    // high, so a stall simply delays all later events by one cycle each.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        base_d      = base_q;
        seed_d      = seed_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        cs_d        = cs_q;
        write_d     = write_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_exp_d  = pipe_exp_q;
        pipe_adr_d  = pipe_adr_q;
        push        = 1'b0;
        older_vld   = pipe_vld_q;
        older_vld[READ_LAT-1] = 1'b0;

        len_clamped = length[ADDR_W] ? MAX_LEN : length;
        last_word   = (idx_q == (len_q - ONE_L));
        exp_word    = seed_q + DATA_W'(idx_q);

        if (!hold) begin
            done_d = 1'b0;

            // Compare the oldest pipeline entry against the slave's data
            if (pipe_vld_q[READ_LAT-1] && (readdata != pipe_exp_q[READ_LAT-1])) begin
                err_d = err_q + ONE_L;
                if (err_q == '0) begin
                    first_d = pipe_adr_q[READ_LAT-1];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_d  = base_addr;
                        seed_d  = seed;
                        len_d   = len_clamped;
                        idx_d   = '0;
                        err_d   = '0;
                        first_d = '0;
                        pass_d  = 1'b0;
                        busy_d  = 1'b1;
                        if (len_clamped == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            state_d     = S_WRITE;
                            address_d   = base_addr;
                            writedata_d = seed;
                            cs_d        = 1'b1;
                            write_d     = 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    if (last_word) begin
                        state_d   = S_READ;
                        idx_d     = '0;
                        address_d = base_q;
                        write_d   = 1'b0;
                    end else begin
                        idx_d       = idx_q + ONE_L;
                        address_d   = address_q + ONE_A;
                        writedata_d = writedata_q + DATA_W'(1);
                    end
                end

                S_READ: begin
                    push = 1'b1;
                    if (last_word) begin
                        state_d = S_DRAIN;
                        cs_d    = 1'b0;
                    end else begin
                        idx_d     = idx_q + ONE_L;
                        address_d = address_q + ONE_A;
                    end
                end

                S_DRAIN: begin
                    // Only the final entry left means it is compared this
                    // cycle, so the result is complete after this edge.
                    if (older_vld == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase

            pipe_vld_d[0] = push;
            pipe_exp_d[0] = exp_word;
            pipe_adr_d[0] = address_q;
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_vld_d[k] = pipe_vld_q[k-1];
                pipe_exp_d[k] = pipe_exp_q[k-1];
                pipe_adr_d[k] = pipe_adr_q[k-1];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            seed_q      <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
            pipe_vld_q  <= '0;
            pipe_exp_q  <= '0;
            pipe_adr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            base_q      <= base_d;
            seed_q      <= seed_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            cs_q        <= cs_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_q     <= first_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_exp_q  <= pipe_exp_d;
            pipe_adr_q  <= pipe_adr_d;
        end
    end

    // The done register stays set while a stall freezes the DONE state, so
    // it is masked by hold to give exactly one pulse in an unstalled cycle.
    assign done           = done_q & ~hold;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign error_count    = err_q;
    assign first_err_addr = first_q;
    assign address        = address_q;
    assign byteenable     = {BE_W{cs_q}};
    assign chipselect     = cs_q;
    assign write          = write_q;
    assign writedata      = writedata_q;
    assign clken          = ~hold;

endmodule

// File: tb/tb_onchip_mem_tester.sv
// Testbench for onchip_mem_tester with a latency-1 RAM model on the bus.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_onchip_mem_tester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] seed;
    logic        hold;
    logic        busy, done, pass;
    logic [10:0] error_count;
    logic [9:0]  first_err_addr;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect, write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onchip_mem_tester #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .seed(seed), .hold(hold), .busy(busy), .done(done),
        .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    // RAM model: 1024 words, read latency 1, everything gated by clken
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    logic [9:0]  rd_adr_q;
    logic        inject;
    logic [31:0] flip;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rd_q     = 32'h0;
        rd_adr_q = 10'h0;
    end

    always @(posedge clk) begin
        if (clken && chipselect) begin
            if (write) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end else begin
                rd_q     <= mem[address];
                rd_adr_q <= address;
            end
        end
    end

    // Fault injection on the returned data for addresses 2 and 3
    always_comb begin
        flip = 32'h0;
        if (inject && rd_adr_q == 10'd2) flip = 32'h0000_0001;
        if (inject && rd_adr_q == 10'd3) flip = 32'h8000_0000;
    end
    assign readdata = rd_q ^ flip;

    // Pulse start for one cycle; returns at the falling edge of cycle 1
    task automatic start_run(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s);
        base_addr = b;
        length    = n;
        seed      = s;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Wait (bounded) for done; dc is the done cycle or -1 on timeout
    task automatic wait_done(input int first_cyc, input int max_cyc, output int dc);
        int cyc;
        cyc = first_cyc;
        while (done !== 1'b1 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        dc = (done === 1'b1) ? cyc : -1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        int dc;
        reset = 1'b1;
        hold  = 1'b0;
        idle_cycles(2);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass got=%b exp=0", pass); end
        total++; if (error_count !== 11'd0) begin bad++; $display("[TB] FAIL reset_errcnt got=%0d exp=0", error_count); end
        total++; if (first_err_addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_firsterr got=%h exp=0", first_err_addr); end
        total++; if (address !== 10'd0) begin bad++; $display("[TB] FAIL reset_address got=%h exp=0", address); end
        total++; if (byteenable !== 4'h0) begin bad++; $display("[TB] FAIL reset_byteenable got=%h exp=0", byteenable); end
        total++; if (chipselect !== 1'b0) begin bad++; $display("[TB] FAIL reset_cs got=%b exp=0", chipselect); end
        total++; if (write !== 1'b0) begin bad++; $display("[TB] FAIL reset_write got=%b exp=0", write); end
        total++; if (writedata !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=0", writedata); end
        total++; if (clken !== 1'b1) begin bad++; $display("[TB] FAIL reset_clken got=%b exp=1", clken); end
        reset = 1'b0;
        idle_cycles(2);

        // Reset in the middle of the write phase
        start_run(10'h080, 11'd8, 32'h0BAD_0000);
        idle_cycles(2);
        reset = 1'b1;
        @(negedge clk);
        total++; if (chipselect !== 1'b0) begin bad++; $display("[TB] FAIL midreset_cs got=%b exp=0", chipselect); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (write !== 1'b0) begin bad++; $display("[TB] FAIL midreset_write got=%b exp=0", write); end
        reset = 1'b0;
        idle_cycles(2);
        start_run(10'h080, 11'd3, 32'h0000_0700);
        wait_done(1, 40, dc);
        total++; if (dc !== 8) begin bad++; $display("[TB] FAIL postreset_done_cycle got=%0d exp=8", dc); end
        total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL postreset_pass got=%b exp=1", pass); end
        idle_cycles(2);
    endtask

    task automatic test_basic;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 4) begin
                total++; if (chipselect !== 1'b1 || write !== 1'b1 || byteenable !== 4'hF) begin
                    bad++; $display("[TB] FAIL basic_wr_ctrl c=%0d got cs=%b wr=%b be=%h exp cs=1 wr=1 be=f", c, chipselect, write, byteenable); end
                total++; if (address !== 10'(c-1)) begin bad++; $display("[TB] FAIL basic_wr_addr c=%0d got=%h exp=%h", c, address, 10'(c-1)); end
                total++; if (writedata !== 32'h1000_0000 + 32'(c-1)) begin
                    bad++; $display("[TB] FAIL basic_wr_data c=%0d got=%h exp=%h", c, writedata, 32'h1000_0000 + 32'(c-1)); end
            end else if (c <= 8) begin
                total++; if (chipselect !== 1'b1 || write !== 1'b0) begin
                    bad++; $display("[TB] FAIL basic_rd_ctrl c=%0d got cs=%b wr=%b exp cs=1 wr=0", c, chipselect, write); end
                total++; if (address !== 10'(c-5)) begin bad++; $display("[TB] FAIL basic_rd_addr c=%0d got=%h exp=%h", c, address, 10'(c-5)); end
            end else begin
                total++; if (chipselect !== 1'b0 || byteenable !== 4'h0) begin
                    bad++; $display("[TB] FAIL basic_drain_cs c=%0d got cs=%b be=%h exp 0", c, chipselect, byteenable); end
            end
            total++; if (done !== (c == 10)) begin bad++; $display("[TB] FAIL basic_done c=%0d got=%b exp=%b", c, done, (c == 10)); end
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy c=%0d got=%b exp=1", c, busy); end
            if (c == 10) begin
                total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL basic_pass got=%b exp=1", pass); end
                total++; if (error_count !== 11'd0) begin bad++; $display("[TB] FAIL basic_errcnt got=%0d exp=0", error_count); end
            end
            if (c < 10) @(negedge clk);
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== 32'h1000_0000 + 32'(i)) begin
                bad++; $display("[TB] FAIL basic_mem[%0d] got=%h exp=%h", i, mem[i], 32'h1000_0000 + 32'(i)); end
        end
        idle_cycles(2);
    endtask

    task automatic test_wrap;
        logic [9:0] exp_adr [0:7];
        int dc;
        exp_adr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FE, 10'h3FF, 10'h000, 10'h001};
        start_run(10'h3FE, 11'd4, 32'hCAFE_0000);
        for (int c = 1; c <= 8; c++) begin
            total++; if (address !== exp_adr[c-1] || chipselect !== 1'b1) begin
                bad++; $display("[TB] FAIL wrap_addr c=%0d got=%h cs=%b exp=%h cs=1", c, address, chipselect, exp_adr[c-1]); end
            @(negedge clk);
        end
        wait_done(9, 40, dc);
        total++; if (dc !== 10) begin bad++; $display("[TB] FAIL wrap_done_cycle got=%0d exp=10", dc); end
        total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL wrap_pass got=%b exp=1", pass); end
        idle_cycles(2);
    endtask

    task automatic test_fault;
        int dc;
        inject = 1'b1;
        start_run(10'h000, 11'd4, 32'h5555_0000);
        wait_done(1, 40, dc);
        total++; if (dc !== 10) begin bad++; $display("[TB] FAIL fault_done_cycle got=%0d exp=10", dc); end
        total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL fault_pass got=%b exp=0", pass); end
        total++; if (error_count !== 11'd2) begin bad++; $display("[TB] FAIL fault_errcnt got=%0d exp=2", error_count); end
        total++; if (first_err_addr !== 10'd2) begin bad++; $display("[TB] FAIL fault_firsterr got=%h exp=2", first_err_addr); end
        inject = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_stall;
        logic [9:0]  s_adr;
        logic [31:0] s_wd;
        logic        s_cs, s_wr;
        int          dc;
        dc = -1;
        start_run(10'h010, 11'd6, 32'h0000_ABC0);
        for (int c = 1; c <= 30 && dc < 0; c++) begin
            if (c >= 10 && c <= 12) begin
                total++; if (address !== s_adr || writedata !== s_wd || chipselect !== s_cs || write !== s_wr) begin
                    bad++; $display("[TB] FAIL stall_bus c=%0d got a=%h cs=%b wr=%b exp a=%h cs=%b wr=%b", c, address, chipselect, write, s_adr, s_cs, s_wr); end
            end
            if (done === 1'b1) dc = c;
            if (c == 9) begin
                s_adr = address; s_wd = writedata; s_cs = chipselect; s_wr = write;
                hold = 1'b1;
                #1;
                total++; if (clken !== 1'b0) begin bad++; $display("[TB] FAIL stall_clken got=%b exp=0", clken); end
                total++; if (s_adr !== 10'h012 || s_cs !== 1'b1) begin
                    bad++; $display("[TB] FAIL stall_snap_addr got=%h cs=%b exp=012 cs=1", s_adr, s_cs); end
            end
            if (c == 12) hold = 1'b0;
            if (dc < 0) @(negedge clk);
        end
        total++; if (dc !== 17) begin bad++; $display("[TB] FAIL stall_done_cycle got=%0d exp=17", dc); end
        total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL stall_pass got=%b exp=1", pass); end
        idle_cycles(2);
    endtask

    task automatic test_len0;
        start_run(10'h123, 11'd0, 32'h1);
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL len0_done got done=%b busy=%b exp 1 1", done, busy); end
        total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL len0_pass got=%b exp=1", pass); end
        total++; if (chipselect !== 1'b0) begin bad++; $display("[TB] FAIL len0_cs got=%b exp=0", chipselect); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || chipselect !== 1'b0) begin
            bad++; $display("[TB] FAIL len0_after got done=%b busy=%b cs=%b exp 0 0 0", done, busy, chipselect); end
        idle_cycles(2);
    endtask

    task automatic test_start_ignored;
        int dc;
        start_run(10'h020, 11'd5, 32'h7777_0000);
        @(negedge clk);
        @(negedge clk);
        base_addr = 10'h300; length = 11'd3; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, 40, dc);
        total++; if (dc !== 12) begin bad++; $display("[TB] FAIL ignore_done_cycle got=%0d exp=12", dc); end
        total++; if (pass !== 1'b1 || error_count !== 11'd0) begin
            bad++; $display("[TB] FAIL ignore_result got pass=%b err=%0d exp 1 0", pass, error_count); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ignore_idle_busy got=%b exp=0", busy); end
        idle_cycles(2);
    endtask

    task automatic test_clamp;
        int dc;
        start_run(10'h100, 11'd2047, 32'hDEAD_0000);
        wait_done(1, 2200, dc);
        total++; if (dc !== 2050) begin bad++; $display("[TB] FAIL clamp_done_cycle got=%0d exp=2050", dc); end
        total++; if (pass !== 1'b1 || error_count !== 11'd0) begin
            bad++; $display("[TB] FAIL clamp_result got pass=%b err=%0d exp 1 0", pass, error_count); end
        total++; if (mem[10'h0FF] !== 32'hDEAD_03FF) begin
            bad++; $display("[TB] FAIL clamp_mem_last got=%h exp=dead03ff", mem[10'h0FF]); end
        idle_cycles(2);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        hold      = 1'b0;
        inject    = 1'b0;
        base_addr = '0;
        length    = '0;
        seed      = '0;
        @(negedge clk);
        test_reset;
        start_run(10'h000, 11'd4, 32'h1000_0000);
        test_basic;
        test_wrap;
        test_fault;
        test_stall;
        test_len0;
        test_start_ignored;
        test_clamp;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_mem_tester.md
# onchip_mem_tester

Avalon-MM master that drives the single-port 32-bit on-chip RAM slave (1024 words, fixed read latency, byteenable, clken) from the other end of its port. On `start` it fills a region with a seed-derived pattern, reads the region back, compares every word against the expected value, and reports pass/fail, an error count and the first failing address. It serves as the RAM bring-up and self-test engine on the DE2 designs, connecting directly to the RAM's s1 port with no interconnect wait states.

## Interface

- `ADDR_W`, 10, word-address width of the RAM slave.
- `DATA_W`, 32, data width; byte lanes = `DATA_W/8`.
- `READ_LAT`, 1, slave read latency in clken-qualified cycles (legal values 1..3).

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled on accepted `start`.
- `length`  in  ADDR_W+1  word count; sampled on accepted `start`; values above 2^ADDR_W are clamped to 2^ADDR_W.
- `seed`  in  DATA_W  pattern seed; sampled on accepted `start`.
- `hold`  in  1  stall request; freezes the master and the slave.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  result of the last run; valid from `done` until the next accepted `start`.
- `error_count`  out  ADDR_W+1  number of mismatching words in the last run.
- `first_err_addr`  out  ADDR_W  address of the first mismatch; 0 if none.
- `address`  out  ADDR_W  slave word address.
- `byteenable`  out  DATA_W/8  all ones while `chipselect` is high, 0 otherwise.
- `chipselect`  out  1  slave select.
- `write`  out  1  write strobe; only high together with `chipselect`.
- `writedata`  out  DATA_W  write data.
- `clken`  out  1  slave clock enable; equals `~hold` (combinational).
- `readdata`  in  DATA_W  slave read data, valid `READ_LAT` enabled cycles after the read address.

## Operation

- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> WRITE on `start`. If the clamped `length` is 0, IDLE goes directly to DONE instead.
- Word index `i` runs from 0 to `length`-1. The address is `base_addr + i` mod 2^ADDR_W, so the region wraps past the top of memory.
- Pattern: `pattern(i) = seed + i` mod 2^DATA_W.
- WRITE:
  - Issues one write per enabled cycle (`chipselect=1`, `write=1`, `writedata=pattern(i)`).
  - Goes to READ after word `length`-1.
- READ:
  - Issues one read per enabled cycle (`chipselect=1`, `write=0`).
  - The expected value and address enter a `READ_LAT`-deep shift register that advances only when `clken=1`.
  - Goes to DRAIN after the last read is issued.
- DRAIN:
  - `chipselect=0`.
  - Waits until the last expected-value entry has been compared, then goes to DONE.
- Compare:
  - Each enabled cycle in which the pipeline output is valid, `readdata` is compared with the expected value.
  - On a mismatch, `error_count` increments. If it is the run's first mismatch, its address is loaded into `first_err_addr`.
- DONE:
  - `done=1` for one cycle, with `pass = (error_count==0)`.
  - Goes to IDLE.
- Accepted `start` clears `error_count`, `first_err_addr` and `pass`.
- `start` outside IDLE is ignored; no queuing.
- `hold=1`:
  - State, counters, pipeline, `address`, `writedata`, `chipselect` and `write` all hold their values.
  - `clken=0`, so the slave neither captures nor advances.
  - No compare happens.
  - `done` is only issued in a cycle with `hold=0`.
- `reset` (including mid-run):
  - Next edge goes to IDLE and empties the pipeline.
  - All outputs take their reset values.
  - Any partial memory contents are left as they are.

## Timing

- Reset values: `busy=0`, `done=0`, `pass=0`, `error_count=0`, `first_err_addr=0`, `address=0`, `byteenable=0`, `chipselect=0`, `write=0`, `writedata=0`. `clken` follows `~hold`.
- Cycle numbering is for `hold=0`, with `start` sampled at the edge ending cycle 0, where N = clamped `length`:
  - Writes are issued in cycles 1..N.
  - Reads are issued in cycles N+1..2N.
  - Data for the read issued in cycle c is compared in cycle c+`READ_LAT`.
  - `done` is asserted in cycle 2N+`READ_LAT`+1, and `busy` drops after that cycle.
- N=0: `done` in cycle 1, with no bus activity.
- Each `hold` cycle delays all later events by exactly one cycle.
- Bus outputs are registered; `clken` is the only combinational output.

## Test plan

- Reset with `hold=0`: every output listed under reset values matches, and `clken=1`. Assert `reset` during WRITE: `chipselect=0` and `busy=0` on the next cycle, and a following run passes.
- `base_addr=0`, `length=4`, `seed=0x1000_0000`, RAM model at latency 1:
  - Writes 0x10000000..0x10000003 to addresses 0..3 in cycles 1..4.
  - Reads in cycles 5..8.
  - `done` in cycle 10, with `pass=1` and `error_count=0`.
- Wrap: `base_addr=0x3FE`, `length=4` -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in both phases; `pass=1`.
- Fault: the bench flips `readdata` bit 0 for address 2 and bit 31 for address 3 -> `pass=0`, `error_count=2`, `first_err_addr=2`.
- Stall: `hold=1` for 3 cycles in the middle of READ -> `clken=0` and bus outputs stable for those cycles; `done` is delayed exactly 3 cycles; `pass=1`.
- Edge cases:
  - `length=0` -> `done` in cycle 1, `pass=1`, no `chipselect`.
  - `start` pulsed while busy is ignored; the result is unchanged.
  - `length=2047` is clamped to 1024, and `done` arrives in cycle 2050.
